// File: rtl/secuenciador_lectura_imagen_if.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_lectura_imagen_if
// Brief    : Configuration, image-memory read and line-buffer write signals
//            of the image read sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface secuenciador_lectura_imagen_if #(
    parameter int BITS_BUS_DATOS_INSTR = 21,
    parameter int BITS_BUFFERS_IMAGEN  = 2,
    parameter int BITS_DATOS_MEM       = 32
);
    logic                            inicio;
    logic [BITS_BUS_DATOS_INSTR-1:0] direccion_mem_inicio_imagen;
    logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_lecturas_mem;
    logic [BITS_BUFFERS_IMAGEN-1:0]  cantidad_buffers_internos;
    logic [BITS_BUS_DATOS_INSTR-1:0] mem_direccion;
    logic                            mem_lectura;
    logic                            mem_espera;
    logic                            mem_dato_valido;
    logic [BITS_DATOS_MEM-1:0]       mem_dato;
    logic                            buffer_escritura;
    logic [BITS_BUFFERS_IMAGEN-1:0]  buffer_seleccion;
    logic [BITS_DATOS_MEM-1:0]       buffer_dato;
    logic                            ocupado;
    logic                            terminado;

    modport master (
        input  inicio, direccion_mem_inicio_imagen, cantidad_lecturas_mem,
               cantidad_buffers_internos, mem_espera, mem_dato_valido, mem_dato,
        output mem_direccion, mem_lectura, buffer_escritura, buffer_seleccion,
               buffer_dato, ocupado, terminado
    );

    modport slave (
        output inicio, direccion_mem_inicio_imagen, cantidad_lecturas_mem,
               cantidad_buffers_internos, mem_espera, mem_dato_valido, mem_dato,
        input  mem_direccion, mem_lectura, buffer_escritura, buffer_seleccion,
               buffer_dato, ocupado, terminado
    );
endinterface
`default_nettype wire

// File: rtl/secuenciador_lectura_imagen.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_lectura_imagen
// Brief    : Issues pipelined image-memory reads and distributes the returned
//            words round-robin over the internal line buffers.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_lectura_imagen #(
    parameter int BITS_BUS_DATOS_INSTR = 21,
    parameter int BITS_BUFFERS_IMAGEN  = 2,
    parameter int BITS_DATOS_MEM       = 32,
    parameter int PALABRAS_POR_BUFFER  = 128,
    parameter int MAX_PENDIENTES       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    secuenciador_lectura_imagen_if.master bus
);
    localparam int c_ANCHO_PEND = $clog2(MAX_PENDIENTES + 1);
    localparam int c_ANCHO_PAL  = (PALABRAS_POR_BUFFER > 1) ? $clog2(PALABRAS_POR_BUFFER) : 1;
    localparam logic [c_ANCHO_PAL-1:0]  c_ULTIMA_PALABRA = c_ANCHO_PAL'(PALABRAS_POR_BUFFER - 1);
    localparam logic [c_ANCHO_PEND-1:0] c_MAX_PEND       = c_ANCHO_PEND'(MAX_PENDIENTES);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        SOLICITUD = 2'd1,
        DRENAJE   = 2'd2,
        FIN       = 2'd3
    } estado_t;

    estado_t                         r_estado;
    logic [BITS_BUS_DATOS_INSTR-1:0] r_direccion;
    logic [BITS_BUS_DATOS_INSTR-1:0] r_cantidad;
    logic [BITS_BUS_DATOS_INSTR-1:0] r_emitidas;
    logic [BITS_BUFFERS_IMAGEN-1:0]  r_buffers;
    logic [c_ANCHO_PEND-1:0]         r_pendientes;
    logic [c_ANCHO_PAL-1:0]          r_palabras;
    logic [BITS_BUFFERS_IMAGEN-1:0]  r_sel_actual;
    logic [BITS_BUFFERS_IMAGEN-1:0]  r_sel_salida;
    logic [BITS_DATOS_MEM-1:0]       r_dato;
    logic                            r_lectura;
    logic                            r_escritura;
    logic                            r_ocupado;
    logic                            r_terminado;

    logic                            w_acepta;
    logic                            w_respuesta;
    logic [c_ANCHO_PEND-1:0]         w_pend_sig;
    logic [BITS_BUS_DATOS_INSTR-1:0] w_emitidas_sig;
    logic [BITS_BUFFERS_IMAGEN-1:0]  w_ultimo_buffer;
    logic [BITS_BUFFERS_IMAGEN-1:0]  w_sel_siguiente;

    assign w_acepta    = r_lectura & ~bus.mem_espera;
    // Responses outside a transfer (e.g. left over from before a reset) are dropped.
    assign w_respuesta = bus.mem_dato_valido & (r_estado != REPOSO) & (r_pendientes != '0);

    assign w_emitidas_sig  = r_emitidas + BITS_BUS_DATOS_INSTR'(w_acepta);
    assign w_ultimo_buffer = (r_buffers == '0) ? '0 : r_buffers - BITS_BUFFERS_IMAGEN'(1);
    assign w_sel_siguiente = (r_sel_actual >= w_ultimo_buffer) ? '0
                           : r_sel_actual + BITS_BUFFERS_IMAGEN'(1);

    always_comb begin
        w_pend_sig = r_pendientes;
        if (w_acepta && !w_respuesta) begin
            w_pend_sig = r_pendientes + c_ANCHO_PEND'(1);
        end else if (!w_acepta && w_respuesta) begin
            w_pend_sig = r_pendientes - c_ANCHO_PEND'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado     <= REPOSO;
            r_direccion  <= '0;
            r_cantidad   <= '0;
            r_emitidas   <= '0;
            r_buffers    <= '0;
            r_pendientes <= '0;
            r_palabras   <= '0;
            r_sel_actual <= '0;
            r_sel_salida <= '0;
            r_dato       <= '0;
            r_lectura    <= 1'b0;
            r_escritura  <= 1'b0;
            r_ocupado    <= 1'b0;
            r_terminado  <= 1'b0;
        end else begin
            r_terminado  <= 1'b0;
            r_pendientes <= w_pend_sig;
            r_escritura  <= w_respuesta;

            // r_sel_actual is the buffer for the next word; r_sel_salida tags the word being written.
            if (w_respuesta) begin
                r_dato       <= bus.mem_dato;
                r_sel_salida <= r_sel_actual;
                if (r_palabras == c_ULTIMA_PALABRA) begin
                    r_palabras   <= '0;
                    r_sel_actual <= w_sel_siguiente;
                end else begin
                    r_palabras <= r_palabras + c_ANCHO_PAL'(1);
                end
            end

            case (r_estado)
                REPOSO: begin
                    if (bus.inicio) begin
                        r_direccion  <= bus.direccion_mem_inicio_imagen;
                        r_cantidad   <= bus.cantidad_lecturas_mem;
                        r_buffers    <= bus.cantidad_buffers_internos;
                        r_emitidas   <= '0;
                        r_palabras   <= '0;
                        r_sel_actual <= '0;
                        r_ocupado    <= 1'b1;
                        if (bus.cantidad_lecturas_mem == '0) begin
                            r_estado <= FIN;
                        end else begin
                            r_estado  <= SOLICITUD;
                            r_lectura <= 1'b1;
                        end
                    end
                end
                SOLICITUD: begin
                    r_direccion <= r_direccion + BITS_BUS_DATOS_INSTR'(w_acepta);
                    r_emitidas  <= w_emitidas_sig;
                    if (w_emitidas_sig == r_cantidad) begin
                        r_lectura <= 1'b0;
                        r_estado  <= DRENAJE;
                    end else begin
                        r_lectura <= (w_pend_sig < c_MAX_PEND);
                    end
                end
                DRENAJE: begin
                    if (r_pendientes == '0) begin
                        r_estado <= FIN;
                    end
                end
                FIN: begin
                    r_estado    <= REPOSO;
                    r_ocupado   <= 1'b0;
                    r_terminado <= 1'b1;
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign bus.mem_direccion    = r_direccion;
    assign bus.mem_lectura      = r_lectura;
    assign bus.buffer_escritura = r_escritura;
    assign bus.buffer_seleccion = r_sel_salida;
    assign bus.buffer_dato      = r_dato;
    assign bus.ocupado          = r_ocupado;
    assign bus.terminado        = r_terminado;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_lectura_imagen.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_lectura_imagen
// Brief    : Directed bench for the image read sequencer; two instances
//            (4 and 2 words per buffer) share one memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secuenciador_lectura_imagen;
    logic clk;
    logic reset;

    secuenciador_lectura_imagen_if #(.BITS_BUS_DATOS_INSTR(21), .BITS_BUFFERS_IMAGEN(2),
                                     .BITS_DATOS_MEM(32)) bus_a ();
    secuenciador_lectura_imagen_if #(.BITS_BUS_DATOS_INSTR(21), .BITS_BUFFERS_IMAGEN(2),
                                     .BITS_DATOS_MEM(32)) bus_b ();

    secuenciador_lectura_imagen #(.PALABRAS_POR_BUFFER(4), .MAX_PENDIENTES(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    secuenciador_lectura_imagen #(.PALABRAS_POR_BUFFER(2), .MAX_PENDIENTES(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    assign bus_b.inicio                      = bus_a.inicio;
    assign bus_b.direccion_mem_inicio_imagen = bus_a.direccion_mem_inicio_imagen;
    assign bus_b.cantidad_lecturas_mem       = bus_a.cantidad_lecturas_mem;
    assign bus_b.cantidad_buffers_internos   = bus_a.cantidad_buffers_internos;
    assign bus_b.mem_espera                  = bus_a.mem_espera;
    assign bus_b.mem_dato_valido             = bus_a.mem_dato_valido;
    assign bus_b.mem_dato                    = bus_a.mem_dato;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [20:0] dir;
        logic [20:0] cantidad;
        logic [1:0]  buffers;
        logic        espera_2da;
        logic        inicio_extra;
        logic [15:0] sel_a;   // expected selects for PALABRAS=4, first write in MSBs
        logic [15:0] sel_b;   // expected selects for PALABRAS=2
    } vector_t;

    typedef struct packed {
        int          vence;
        logic [31:0] dato;
    } resp_t;

    vector_t     tabla [6];
    resp_t       cola [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          emitidas, escrituras_a, escrituras_b, pulsos_fin, escrituras_en_fin;
    int          indice_espera, espera_restante, ciclos_retenidos, validos_enviados;
    bit          sin_respuesta;
    logic [20:0] base;
    logic [15:0] sel_a_esp, sel_b_esp;

    function automatic logic [31:0] dato_de(input logic [20:0] a);
        return {11'h2B5, a};
    endfunction

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nombre, actual, esperado);
        end
    endtask

    task automatic preparar(input logic [20:0] dir, input logic [15:0] sa, input logic [15:0] sb,
                            input int idx_espera);
        base = dir; sel_a_esp = sa; sel_b_esp = sb;
        emitidas = 0; escrituras_a = 0; escrituras_b = 0; pulsos_fin = 0; escrituras_en_fin = -1;
        indice_espera = idx_espera; espera_restante = 3; ciclos_retenidos = 0;
        sin_respuesta = 1'b0;
        cola.delete();
    endtask

    // One clock of the memory model plus output monitoring, at the falling edge.
    task automatic ciclo();
        int          previas;
        logic [20:0] dir_esp;
        @(negedge clk);
        cyc++;
        previas = escrituras_a;
        dir_esp = base + 21'(emitidas);
        if (bus_a.mem_lectura && emitidas == indice_espera && espera_restante > 0) begin
            bus_a.mem_espera = 1'b1;
            espera_restante--;
            ciclos_retenidos++;
            chk("direccion_retenida", 32'(bus_a.mem_direccion), 32'(dir_esp));
        end else begin
            bus_a.mem_espera = 1'b0;
        end
        if (bus_a.mem_lectura && !bus_a.mem_espera) begin
            chk($sformatf("direccion_%0d", emitidas), 32'(bus_a.mem_direccion), 32'(dir_esp));
            cola.push_back('{cyc + 2, dato_de(bus_a.mem_direccion)});
            emitidas++;
        end
        if (!sin_respuesta && cola.size() > 0 && cola[0].vence <= cyc) begin
            bus_a.mem_dato_valido = 1'b1;
            bus_a.mem_dato = cola[0].dato;
            void'(cola.pop_front());
            validos_enviados++;
        end else begin
            bus_a.mem_dato_valido = 1'b0;
            bus_a.mem_dato = 32'h0;
        end
        if (bus_a.buffer_escritura) begin
            chk($sformatf("dato_a_%0d", escrituras_a), bus_a.buffer_dato, dato_de(base + 21'(escrituras_a)));
            if (escrituras_a < 8)
                chk($sformatf("sel_a_%0d", escrituras_a), 32'(bus_a.buffer_seleccion),
                    32'(sel_a_esp[15-2*escrituras_a -: 2]));
            escrituras_a++;
        end
        if (bus_b.buffer_escritura) begin
            chk($sformatf("dato_b_%0d", escrituras_b), bus_b.buffer_dato, dato_de(base + 21'(escrituras_b)));
            if (escrituras_b < 8)
                chk($sformatf("sel_b_%0d", escrituras_b), 32'(bus_b.buffer_seleccion),
                    32'(sel_b_esp[15-2*escrituras_b -: 2]));
            escrituras_b++;
        end
        if (bus_a.terminado) begin
            pulsos_fin++;
            escrituras_en_fin = previas;
        end
    endtask

    task automatic arrancar(input logic [20:0] dir, input logic [20:0] cant, input logic [1:0] bufs);
        bus_a.direccion_mem_inicio_imagen = dir;
        bus_a.cantidad_lecturas_mem = cant;
        bus_a.cantidad_buffers_internos = bufs;
        bus_a.inicio = 1'b1;
        ciclo();
        bus_a.inicio = 1'b0;
        // Configuration changes after the start must not matter.
        bus_a.direccion_mem_inicio_imagen = ~dir;
        bus_a.cantidad_lecturas_mem = 21'd3;
        bus_a.cantidad_buffers_internos = 2'd1;
    endtask

    task automatic transferencia(input int n, input vector_t v);
        preparar(v.dir, v.sel_a, v.sel_b, v.espera_2da ? 1 : -1);
        arrancar(v.dir, v.cantidad, v.buffers);
        for (int it = 0; it < 300 && pulsos_fin == 0; it++) begin
            bus_a.inicio = (v.inicio_extra && it == 3);
            ciclo();
        end
        bus_a.inicio = 1'b0;
        ciclo();
        ciclo();
        chk($sformatf("v%0d_lecturas", n), 32'(emitidas), 32'(v.cantidad));
        chk($sformatf("v%0d_escrituras_a", n), 32'(escrituras_a), 32'(v.cantidad));
        chk($sformatf("v%0d_escrituras_b", n), 32'(escrituras_b), 32'(v.cantidad));
        chk($sformatf("v%0d_pulsos_terminado", n), 32'(pulsos_fin), 32'd1);
        chk($sformatf("v%0d_escritura_antes_fin", n), 32'(escrituras_en_fin), 32'(v.cantidad));
        chk($sformatf("v%0d_ocupado_final", n), 32'(bus_a.ocupado), 32'd0);
        if (v.espera_2da)
            chk($sformatf("v%0d_ciclos_espera", n), 32'(ciclos_retenidos), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int w0, t0, v0;
        tabla[0] = '{21'h100,    21'd8, 2'd2, 1'b0, 1'b0,
                     {2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd1}, {2'd0,2'd0,2'd1,2'd1,2'd0,2'd0,2'd1,2'd1}};
        tabla[1] = '{21'h100,    21'd8, 2'd2, 1'b1, 1'b0,
                     {2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd1}, {2'd0,2'd0,2'd1,2'd1,2'd0,2'd0,2'd1,2'd1}};
        tabla[2] = '{21'h040,    21'd8, 2'd3, 1'b0, 1'b1,
                     {2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd1}, {2'd0,2'd0,2'd1,2'd1,2'd2,2'd2,2'd0,2'd0}};
        tabla[3] = '{21'h200,    21'd6, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0};
        tabla[4] = '{21'h1FFFFE, 21'd4, 2'd1, 1'b0, 1'b0, 16'h0, 16'h0};
        tabla[5] = '{21'h010,    21'd5, 2'd2, 1'b0, 1'b0,
                     {2'd0,2'd0,2'd0,2'd0,2'd1,2'd0,2'd0,2'd0}, {2'd0,2'd0,2'd1,2'd1,2'd0,2'd0,2'd0,2'd0}};

        reset = 1'b1;
        bus_a.inicio = 1'b0;
        bus_a.direccion_mem_inicio_imagen = '0;
        bus_a.cantidad_lecturas_mem = '0;
        bus_a.cantidad_buffers_internos = '0;
        bus_a.mem_espera = 1'b0;
        bus_a.mem_dato_valido = 1'b0;
        bus_a.mem_dato = '0;
        validos_enviados = 0;
        preparar(21'h0, 16'h0, 16'h0, -1);
        repeat (3) @(negedge clk);
        chk("reset_mem_lectura", 32'(bus_a.mem_lectura), 32'd0);
        chk("reset_mem_direccion", 32'(bus_a.mem_direccion), 32'd0);
        chk("reset_ocupado", 32'(bus_a.ocupado), 32'd0);
        chk("reset_terminado", 32'(bus_a.terminado), 32'd0);
        chk("reset_escritura", 32'(bus_a.buffer_escritura), 32'd0);
        chk("reset_seleccion", 32'(bus_a.buffer_seleccion), 32'd0);
        chk("reset_dato", bus_a.buffer_dato, 32'd0);
        reset = 1'b0;
        ciclo();

        for (int i = 0; i < 6; i++) transferencia(i, tabla[i]);

        // Zero-length transfer: one busy cycle, terminado the cycle after.
        preparar(21'h300, 16'h0, 16'h0, -1);
        arrancar(21'h300, 21'd0, 2'd1);
        chk("cero_ocupado_c1", 32'(bus_a.ocupado), 32'd1);
        chk("cero_terminado_c1", 32'(bus_a.terminado), 32'd0);
        ciclo();
        chk("cero_ocupado_c2", 32'(bus_a.ocupado), 32'd0);
        chk("cero_terminado_c2", 32'(bus_a.terminado), 32'd1);
        ciclo();
        ciclo();
        chk("cero_pulsos", 32'(pulsos_fin), 32'd1);
        chk("cero_lecturas", 32'(emitidas), 32'd0);

        // Memory never answers: outstanding reads cap at four.
        preparar(21'h500, 16'h0, 16'h0, -1);
        sin_respuesta = 1'b1;
        arrancar(21'h500, 21'd10, 2'd1);
        repeat (20) ciclo();
        chk("sinresp_aceptadas", 32'(emitidas), 32'd4);
        chk("sinresp_mem_lectura", 32'(bus_a.mem_lectura), 32'd0);
        chk("sinresp_ocupado", 32'(bus_a.ocupado), 32'd1);
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        preparar(21'h0, 16'h0, 16'h0, -1);
        ciclo();
        chk("sinresp_tras_reset_ocupado", 32'(bus_a.ocupado), 32'd0);

        // Reset mid-transfer, then stale responses must be ignored.
        preparar(21'h300, tabla[0].sel_a, tabla[0].sel_b, -1);
        arrancar(21'h300, 21'd8, 2'd2);
        for (int it = 0; it < 20 && emitidas < 3; it++) ciclo();
        chk("reset_medio_aceptadas", 32'(emitidas >= 3), 32'd1);
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        chk("reset_medio_salidas", {28'h0, bus_a.ocupado, bus_a.mem_lectura,
                                    bus_a.buffer_escritura, bus_a.terminado}, 32'd0);
        w0 = escrituras_a; t0 = pulsos_fin; v0 = validos_enviados;
        repeat (6) ciclo();
        chk("reset_obsoletos_enviados", 32'(validos_enviados > v0), 32'd1);
        chk("reset_sin_escritura", 32'(escrituras_a), 32'(w0));
        chk("reset_sin_terminado", 32'(pulsos_fin), 32'(t0));
        chk("reset_ocupado_bajo", 32'(bus_a.ocupado), 32'd0);
        transferencia(6, '{21'h080, 21'd4, 2'd1, 1'b0, 1'b0, 16'h0, 16'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
